lcd_ci_sequencer: RTL and testbench

- Parametrised HD44780 character-LCD controller behind the Nios II custom-instruction port (`clk_en`/`start`/`done`/`dataa`/`datab`/`result`).
- Successor to the single-cycle LCD command encoder. It drives the physical bus itself:
  - generates setup, enable-pulse and hold timing;
  - supports 8-bit or 4-bit bus mode;
  - inserts per-command execution waits;
  - holds `done` low until the transfer is complete.
- Sits between the CPU custom-instruction slot and the LCD pins.

---
 rtl/lcd_ci_sequencer.sv | 271 +++++++++++++++++++++++++++
 tb/tb_lcd_ci_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_ci_sequencer.sv
// HD44780 bus sequencer behind a Nios II custom-instruction slot: setup/E-pulse/hold timing, 4/8-bit bus, execution waits.
// Define LCD_SEQ_INIT_EN to build the power-on init ROM behind opcode 0x03.
module lcd_ci_sequencer #(
   parameter int BUS_WIDTH         = 8,
   parameter int SETUP_CYCLES      = 3,
   parameter int EN_PULSE_CYCLES   = 12,
   parameter int CMD_WAIT_CYCLES   = 2000,
   parameter int CLEAR_WAIT_CYCLES = 82000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clk_en,
   input  logic        start,
   input  logic [31:0] dataa,
   input  logic [31:0] datab,
   output logic [31:0] result,
   output logic        done,
   output logic [7:0]  lcd_data,
   output logic        lcd_rs,
   output logic        lcd_rw,
   output logic        lcd_en,
   output logic        lcd_backlight
);

   localparam int MAX_SP  = (SETUP_CYCLES > EN_PULSE_CYCLES) ? SETUP_CYCLES : EN_PULSE_CYCLES;
   localparam int MAX_WT  = (CMD_WAIT_CYCLES > CLEAR_WAIT_CYCLES) ? CMD_WAIT_CYCLES : CLEAR_WAIT_CYCLES;
   localparam int MAX_LEN = (MAX_SP > MAX_WT) ? MAX_SP : MAX_WT;
   localparam int CNT_W   = $clog2(MAX_LEN + 1);

   localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
   localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(EN_PULSE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_WAIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_WAIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_PULSE,
      ST_HOLD,
      ST_WAIT,
      ST_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       byte_q, byte_d;
   logic             rs_q, rs_d;
   logic             err_q, err_d;
   logic             nib_lo_q, nib_lo_d;
   logic             single_q, single_d;
   logic             wait_clr_q, wait_clr_d;
   logic             backlight_q, backlight_d;
   logic [7:0]       lcd_data_q, lcd_data_d;
   logic             lcd_rs_q, lcd_rs_d;
   logic             lcd_en_q, lcd_en_d;
   logic             done_q, done_d;
   logic [31:0]      result_q, result_d;
   logic [CNT_W-1:0] wait_last;

   logic unused_bits;
   assign unused_bits = ^{dataa[31:8], datab[31:8]};

   // In 4-bit mode only lcd_data[7:4] is wired to the panel.
   function automatic logic [7:0] bus_word(input logic [7:0] b, input logic lo);
      if (BUS_WIDTH == 4) begin
         return lo ? {b[3:0], 4'h0} : {b[7:4], 4'h0};
      end
      return b;
   endfunction

`ifdef LCD_SEQ_INIT_EN
   localparam logic [2:0] INIT_LAST = (BUS_WIDTH == 4) ? 3'd7 : 3'd6;

   logic       init_act_q, init_act_d;
   logic [2:0] init_idx_q, init_idx_d;
   logic [9:0] rom_step;

   // Each entry is {single_nibble, force_clear_wait, byte}.
   function automatic logic [9:0] init_step(input logic [2:0] idx);
      logic [9:0] s;
      if (BUS_WIDTH == 4) begin
         case (idx)
            3'd0, 3'd1, 3'd2: s = {2'b11, 8'h30};
            3'd3:             s = {2'b11, 8'h20};
            3'd4:             s = {2'b00, 8'h28};
            3'd5:             s = {2'b00, 8'h0C};
            3'd6:             s = {2'b01, 8'h01};
            default:          s = {2'b00, 8'h06};
         endcase
      end else begin
         case (idx)
            3'd0, 3'd1, 3'd2: s = {2'b01, 8'h30};
            3'd3:             s = {2'b00, 8'h38};
            3'd4:             s = {2'b00, 8'h0C};
            3'd5:             s = {2'b01, 8'h01};
            default:          s = {2'b00, 8'h06};
         endcase
      end
      return s;
   endfunction
`endif

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      byte_d      = byte_q;
      rs_d        = rs_q;
      err_d       = err_q;
      nib_lo_d    = nib_lo_q;
      single_d    = single_q;
      wait_clr_d  = wait_clr_q;
      backlight_d = backlight_q;
      lcd_data_d  = lcd_data_q;
      lcd_rs_d    = lcd_rs_q;
      result_d    = result_q;
`ifdef LCD_SEQ_INIT_EN
      init_act_d  = init_act_q;
      init_idx_d  = init_idx_q;
      rom_step    = init_step(init_idx_q + 3'd1);
`endif
      wait_last   = wait_clr_q ? CLEAR_LAST : CMD_LAST;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               byte_d     = datab[7:0];
               rs_d       = (dataa[7:0] == 8'h01);
               err_d      = 1'b0;
               nib_lo_d   = 1'b0;
               single_d   = 1'b0;
               wait_clr_d = (dataa[7:0] == 8'h00) && (datab[7:0] <= 8'h03);
               cnt_d      = '0;
               case (dataa[7:0])
                  8'h00, 8'h01: state_d = ST_SETUP;
                  8'h02: begin
                     backlight_d = datab[0];
                     state_d     = ST_DONE;
                  end
`ifdef LCD_SEQ_INIT_EN
                  8'h03: begin
                     init_act_d = 1'b1;
                     init_idx_d = 3'd0;
                     {single_d, wait_clr_d, byte_d} = init_step(3'd0);
                     state_d    = ST_SETUP;
                  end
`endif
                  default: begin
                     err_d   = 1'b1;
                     state_d = ST_DONE;
                  end
               endcase
            end
         end
         ST_SETUP: begin
            if (cnt_q == SETUP_LAST) begin
               cnt_d   = '0;
               state_d = ST_PULSE;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_PULSE: begin
            if (cnt_q == PULSE_LAST) begin
               cnt_d   = '0;
               state_d = ST_HOLD;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_HOLD: begin
            if (cnt_q == SETUP_LAST) begin
               cnt_d = '0;
               // Full bytes on a 4-bit bus go round again for the low nibble.
               if (BUS_WIDTH == 4 && !single_q && !nib_lo_q) begin
                  nib_lo_d = 1'b1;
                  state_d  = ST_SETUP;
               end else begin
                  state_d = ST_WAIT;
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_WAIT: begin
            if (cnt_q == wait_last) begin
               cnt_d   = '0;
               state_d = ST_DONE;
`ifdef LCD_SEQ_INIT_EN
               if (init_act_q) begin
                  if (init_idx_q != INIT_LAST) begin
                     init_idx_d = init_idx_q + 3'd1;
                     {single_d, wait_clr_d, byte_d} = rom_step;
                     nib_lo_d   = 1'b0;
                     state_d    = ST_SETUP;
                  end else begin
                     init_act_d = 1'b0;
                  end
               end
`endif
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // Bus value changes only at the start of a transfer, so it is stable through setup, pulse and hold.
      if (state_d == ST_SETUP && state_q != ST_SETUP) begin
         lcd_data_d = bus_word(byte_d, nib_lo_d);
         lcd_rs_d   = rs_d;
      end
      if (state_d == ST_DONE && state_q != ST_DONE) begin
         result_d = {err_d, 21'd0, backlight_d, rs_d, byte_d};
      end
      lcd_en_d = (state_d == ST_PULSE);
      done_d   = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         byte_q      <= 8'h00;
         rs_q        <= 1'b0;
         err_q       <= 1'b0;
         nib_lo_q    <= 1'b0;
         single_q    <= 1'b0;
         wait_clr_q  <= 1'b0;
         backlight_q <= 1'b1;
         lcd_data_q  <= 8'h00;
         lcd_rs_q    <= 1'b0;
         lcd_en_q    <= 1'b0;
         done_q      <= 1'b0;
         result_q    <= 32'h0;
`ifdef LCD_SEQ_INIT_EN
         init_act_q  <= 1'b0;
         init_idx_q  <= 3'd0;
`endif
      end else if (clk_en) begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         byte_q      <= byte_d;
         rs_q        <= rs_d;
         err_q       <= err_d;
         nib_lo_q    <= nib_lo_d;
         single_q    <= single_d;
         wait_clr_q  <= wait_clr_d;
         backlight_q <= backlight_d;
         lcd_data_q  <= lcd_data_d;
         lcd_rs_q    <= lcd_rs_d;
         lcd_en_q    <= lcd_en_d;
         done_q      <= done_d;
         result_q    <= result_d;
`ifdef LCD_SEQ_INIT_EN
         init_act_q  <= init_act_d;
         init_idx_q  <= init_idx_d;
`endif
      end
   end

   assign result        = result_q;
   assign done          = done_q;
   assign lcd_data      = lcd_data_q;
   assign lcd_rs        = lcd_rs_q;
   assign lcd_rw        = 1'b0;
   assign lcd_en        = lcd_en_q;
   assign lcd_backlight = backlight_q;

endmodule

// File: tb/tb_lcd_ci_sequencer.sv
// Randomised bench for lcd_ci_sequencer: an 8-bit and a 4-bit instance share the CPU-side stimulus,
// each checked against a transfer-list model of the expected E pulses, latency and result.
`timescale 1ns/1ps
module tb_lcd_ci_sequencer;
   localparam int S     = 2;
   localparam int P     = 4;
   localparam int CMW   = 10;
   localparam int CLW   = 50;
   localparam int NDUT  = 2;
   localparam int HMAX  = 1024;
   localparam int MAXP  = 16;
   localparam int NOGAP = 1 << 30;
`ifdef LCD_SEQ_INIT_EN
   localparam bit INIT_EN = 1'b1;
`else
   localparam bit INIT_EN = 1'b0;
`endif
   localparam logic [7:0] INIT8 [7] = '{8'h30, 8'h30, 8'h30, 8'h38, 8'h0C, 8'h01, 8'h06};
   localparam logic [7:0] INIT4 [8] = '{8'h30, 8'h30, 8'h30, 8'h20, 8'h28, 8'h0C, 8'h01, 8'h06};

   logic        clk = 1'b0;
   logic        reset, clk_en, start;
   logic [31:0] dataa, datab;
   logic [31:0] result_o   [NDUT];
   logic        done_o     [NDUT];
   logic [7:0]  lcd_data_o [NDUT];
   logic        lcd_rs_o   [NDUT];
   logic        lcd_rw_o   [NDUT];
   logic        lcd_en_o   [NDUT];
   logic        lcd_bl_o   [NDUT];

   always #5 clk = ~clk;

   lcd_ci_sequencer #(.BUS_WIDTH(8), .SETUP_CYCLES(S), .EN_PULSE_CYCLES(P),
                      .CMD_WAIT_CYCLES(CMW), .CLEAR_WAIT_CYCLES(CLW)) dut8 (
      .clk(clk), .reset(reset), .clk_en(clk_en), .start(start), .dataa(dataa), .datab(datab),
      .result(result_o[0]), .done(done_o[0]), .lcd_data(lcd_data_o[0]), .lcd_rs(lcd_rs_o[0]),
      .lcd_rw(lcd_rw_o[0]), .lcd_en(lcd_en_o[0]), .lcd_backlight(lcd_bl_o[0]));

   lcd_ci_sequencer #(.BUS_WIDTH(4), .SETUP_CYCLES(S), .EN_PULSE_CYCLES(P),
                      .CMD_WAIT_CYCLES(CMW), .CLEAR_WAIT_CYCLES(CLW)) dut4 (
      .clk(clk), .reset(reset), .clk_en(clk_en), .start(start), .dataa(dataa), .datab(datab),
      .result(result_o[1]), .done(done_o[1]), .lcd_data(lcd_data_o[1]), .lcd_rs(lcd_rs_o[1]),
      .lcd_rw(lcd_rw_o[1]), .lcd_en(lcd_en_o[1]), .lcd_backlight(lcd_bl_o[1]));

   int   n_tests = 0;
   int   n_fail  = 0;
   int   n_txn   = 0;
   logic model_bl;

   int         exp_n    [NDUT];
   int         exp_a    [NDUT][MAXP];
   int         exp_b    [NDUT][MAXP];
   logic [8:0] exp_word [NDUT][MAXP];
   int         obs_n    [NDUT];
   int         obs_a    [NDUT][MAXP];
   int         obs_b    [NDUT][MAXP];
   logic [8:0] obs_word [NDUT][MAXP];
   logic [8:0] hist     [NDUT][HMAX];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int exec_wait(input logic [7:0] b, input bit rs, input bit force_clr);
      return (force_clr || (!rs && b <= 8'h03)) ? CLW : CMW;
   endfunction

   // Stretch a nominal pulse [a,b] by a clk_en-low window of gl cycles starting in cycle g0.
   task automatic add_pulse(input int d, input int a, input int b, input logic [7:0] data,
                            input bit rs, input int g0, input int gl);
      int k;
      k = exp_n[d];
      exp_a[d][k]    = (a <= g0) ? a : a + gl;
      exp_b[d][k]    = (b < g0) ? b : b + gl;
      exp_word[d][k] = {rs, data};
      exp_n[d]       = k + 1;
   endtask

   task automatic build_model(input int d, input logic [7:0] op, input logic [7:0] b,
                              input int g0, input int gl, output int lat, output logic [31:0] res);
      int         t, nsteps, w;
      logic [7:0] sb;
      bit         rs, single, fclr, is_init, err;
      w       = (d == 0) ? 8 : 4;
      exp_n[d] = 0;
      rs      = (op == 8'h01);
      is_init = (op == 8'h03) && INIT_EN;
      err     = 1'b0;
      t       = 1;
      if (op == 8'h00 || op == 8'h01 || is_init) begin
         nsteps = is_init ? ((w == 4) ? 8 : 7) : 1;
         for (int k = 0; k < nsteps; k++) begin
            if (!is_init) begin
               sb = b; single = 1'b0; fclr = 1'b0;
            end else if (w == 8) begin
               sb = INIT8[k]; single = 1'b0; fclr = (sb == 8'h30);
            end else begin
               sb = INIT4[k]; single = (k < 4); fclr = single || (sb == 8'h30);
            end
            if (w == 8) begin
               add_pulse(d, t + S, t + S + P - 1, sb, rs, g0, gl);
               t += 2 * S + P;
            end else begin
               add_pulse(d, t + S, t + S + P - 1, {sb[7:4], 4'h0}, rs, g0, gl);
               t += 2 * S + P;
               if (!single) begin
                  add_pulse(d, t + S, t + S + P - 1, {sb[3:0], 4'h0}, rs, g0, gl);
                  t += 2 * S + P;
               end
            end
            t += exec_wait(sb, rs, fclr);
         end
         if (is_init) sb = 8'h06;
         else         sb = b;
      end else begin
         err = (op != 8'h02);
         sb  = b;
      end
      lat = (t <= g0) ? t : t + gl;
      res = {err, 21'd0, model_bl, rs, sb};
   endtask

   task automatic run_txn(input logic [7:0] op, input logic [7:0] b, input int g0, input int gl,
                          input bit noise);
      int          lat [NDUT];
      logic [31:0] exp_res [NDUT];
      int          first_done [NDUT];
      int          ndone [NDUT];
      logic [31:0] res_done [NDUT];
      bit          prev_en [NDUT];
      bit          rw_seen [NDUT];
      int          lmin, win, bad, k, lo, hi;
      logic [31:0] rnd;
      if (op == 8'h02) model_bl = b[0];
      for (int d = 0; d < NDUT; d++) begin
         build_model(d, op, b, g0, gl, lat[d], exp_res[d]);
         obs_n[d] = 0; first_done[d] = -1; ndone[d] = 0; res_done[d] = 32'h0;
         prev_en[d] = 1'b0; rw_seen[d] = 1'b0;
      end
      lmin = (lat[0] < lat[1]) ? lat[0] : lat[1];
      win  = ((lat[0] > lat[1]) ? lat[0] : lat[1]) + 3;
      n_txn++;
      $display("[TB] txn %0d op=%h byte=%h gap=%0d+%0d noise=%0d lat8=%0d lat4=%0d",
               n_txn, op, b, (gl == 0) ? 0 : g0, gl, noise, lat[0], lat[1]);

      @(negedge clk);
      rnd = $urandom; dataa = {rnd[31:8], op};
      rnd = $urandom; datab = {rnd[31:8], b};
      start = 1'b1; clk_en = 1'b1;
      for (int c = 1; c <= win; c++) begin
         @(negedge clk);
         for (int d = 0; d < NDUT; d++) begin
            if (c < HMAX) hist[d][c] = {lcd_rs_o[d], lcd_data_o[d]};
            if (lcd_rw_o[d]) rw_seen[d] = 1'b1;
            if (lcd_en_o[d] && !prev_en[d]) begin
               if (obs_n[d] < MAXP) begin
                  obs_a[d][obs_n[d]]    = c;
                  obs_word[d][obs_n[d]] = {lcd_rs_o[d], lcd_data_o[d]};
               end
               obs_n[d]++;
            end
            if (lcd_en_o[d] && obs_n[d] > 0 && obs_n[d] <= MAXP) obs_b[d][obs_n[d]-1] = c;
            prev_en[d] = lcd_en_o[d];
            if (done_o[d]) begin
               ndone[d]++;
               if (first_done[d] < 0) begin
                  first_done[d] = c;
                  res_done[d]   = result_o[d];
               end
            end
         end
         clk_en = !(c >= g0 && c < g0 + gl);
         start  = noise && (c < lmin) && ($urandom_range(0, 2) == 0);
         if (start) begin
            dataa = $urandom;
            datab = $urandom;
         end
      end
      start = 1'b0; clk_en = 1'b1;

      for (int d = 0; d < NDUT; d++) begin
         check($sformatf("dut%0d done_cycle", d), first_done[d], lat[d]);
         check($sformatf("dut%0d done_count", d), ndone[d], 1);
         check($sformatf("dut%0d result_at_done", d), res_done[d], exp_res[d]);
         check($sformatf("dut%0d result_held", d), result_o[d], exp_res[d]);
         check($sformatf("dut%0d backlight", d), lcd_bl_o[d], model_bl);
         check($sformatf("dut%0d rw_low", d), rw_seen[d], 0);
         check($sformatf("dut%0d pulse_count", d), obs_n[d], exp_n[d]);
         for (int p = 0; p < exp_n[d] && p < obs_n[d] && p < MAXP; p++) begin
            check($sformatf("dut%0d pulse%0d rs_data", d, p), obs_word[d][p], exp_word[d][p]);
            check($sformatf("dut%0d pulse%0d start", d, p), obs_a[d][p], exp_a[d][p]);
            check($sformatf("dut%0d pulse%0d width", d, p), obs_b[d][p] - obs_a[d][p] + 1,
                  exp_b[d][p] - exp_a[d][p] + 1);
            bad = 0;
            lo  = obs_a[d][p] - S;
            hi  = obs_b[d][p] + S;
            for (k = lo; k <= hi; k++) begin
               if (k >= 1 && k <= win && k < HMAX && hist[d][k] !== obs_word[d][p]) bad++;
            end
            check($sformatf("dut%0d pulse%0d bus_unstable_cycles", d, p), bad, 0);
         end
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      for (int d = 0; d < NDUT; d++) begin
         check($sformatf("%s dut%0d en", tag, d), lcd_en_o[d], 0);
         check($sformatf("%s dut%0d done", tag, d), done_o[d], 0);
         check($sformatf("%s dut%0d result", tag, d), result_o[d], 32'h0);
         check($sformatf("%s dut%0d data", tag, d), lcd_data_o[d], 8'h00);
         check($sformatf("%s dut%0d rs", tag, d), lcd_rs_o[d], 0);
         check($sformatf("%s dut%0d rw", tag, d), lcd_rw_o[d], 0);
         check($sformatf("%s dut%0d backlight", tag, d), lcd_bl_o[d], 1);
      end
   endtask

   // Reset lands in cycle 11: the 8-bit unit is waiting, the 4-bit unit is mid second E pulse.
   task automatic run_reset_abort();
      int ndone;
      n_txn++;
      $display("[TB] txn %0d reset abort during CMD 38", n_txn);
      @(negedge clk);
      dataa = 32'h0; datab = 32'h38; start = 1'b1; clk_en = 1'b1;
      for (int c = 1; c <= 11; c++) begin
         @(negedge clk);
         start = 1'b0;
      end
      check("abort pre dut8 en", lcd_en_o[0], 0);
      check("abort pre dut4 en", lcd_en_o[1], 1);
      #1 reset = 1'b1;
      #1;
      check_reset_outputs("abort");
      repeat (2) @(negedge clk);
      reset = 1'b0;
      ndone = 0;
      repeat (60) begin
         @(negedge clk);
         for (int d = 0; d < NDUT; d++) if (done_o[d] || lcd_en_o[d]) ndone++;
      end
      check("abort no_done_or_en_after", ndone, 0);
      model_bl = 1'b1;
   endtask

   task automatic run_random(input int n);
      int          r, l0, l1, g0, gl, lraw;
      logic [7:0]  op, b;
      logic [31:0] dummy;
      bit          noise;
      for (int i = 0; i < n; i++) begin
         r = $urandom_range(0, 9);
         if (r <= 3)      op = 8'h00;
         else if (r <= 6) op = 8'h01;
         else if (r == 7) op = 8'h02;
         else if (r == 8) op = 8'h03;
         else             op = 8'($urandom_range(4, 255));
         if ($urandom_range(0, 1) == 1) b = 8'($urandom_range(0, 3));
         else                           b = 8'($urandom_range(0, 255));
         build_model(0, op, b, NOGAP, 0, l0, dummy);
         build_model(1, op, b, NOGAP, 0, l1, dummy);
         lraw  = (l0 < l1) ? l0 : l1;
         noise = ($urandom_range(0, 2) == 0);
         if (lraw > 1 && $urandom_range(0, 1) == 1) begin
            g0 = $urandom_range(1, lraw - 1);
            gl = $urandom_range(1, 5);
         end else begin
            g0 = NOGAP;
            gl = 0;
         end
         run_txn(op, b, g0, gl, noise);
      end
   endtask

   initial begin
      reset = 1'b1; clk_en = 1'b1; start = 1'b0; dataa = 32'h0; datab = 32'h0;
      model_bl = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      reset = 1'b0;
      @(negedge clk);
      check_reset_outputs("post_reset");

      run_txn(8'h00, 8'h38, NOGAP, 0, 1'b0);
      run_txn(8'h00, 8'h01, NOGAP, 0, 1'b1);
      run_txn(8'h01, 8'h41, NOGAP, 0, 1'b0);
      run_txn(8'h02, 8'h00, NOGAP, 0, 1'b0);
      run_txn(8'h7F, 8'h5A, NOGAP, 0, 1'b0);
      run_txn(8'h00, 8'h38, 4, 5, 1'b0);
      run_txn(8'h02, 8'h01, NOGAP, 0, 1'b0);
      run_txn(8'h03, 8'h00, NOGAP, 0, 1'b1);
      run_reset_abort();
      run_random(24);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
